qei_decoder: RTL and testbench
==============================

# qei_decoder

Quadrature encoder front end for the servo FPGA. It conditions the raw A/B/Z encoder pins through a synchronizer and a digital glitch filter, then decodes x4 quadrature into a signed-wrap position counter. It latches the position on each index pulse and counts illegal transitions. It sits between the ENC_A/ENC_B/ENC_Z board pins and the position consumer in the Qsys system, and presents a register-ready position for the Avalon slave wrapper.

## Interface
Parameters:
- FILTER_LEN, 4, consecutive cycles a synchronized input must differ from its filtered value before the filtered value changes; legal range 1..255
- CNT_WIDTH, 32, width of pos and index_pos

Ports:
- clk  in  1  system clock (50 MHz)
- reset_n  in  1  asynchronous, active-low reset
- encabz  in  3  raw encoder pins {A, B, Z}, asynchronous to clk
- clr  in  1  synchronous position clear, level-sensitive
- pos  out  CNT_WIDTH  current position count
- index_pos  out  CNT_WIDTH  position captured at last Z rising edge
- index_valid  out  1  one-cycle pulse when index_pos is updated
- count_strb  out  1  one-cycle pulse when pos changes by ±1
- dir  out  1  direction of last valid step, 1 = forward
- err_count  out  8  illegal-transition count, saturates at 255

## Operation
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Synchronizer: each encabz bit passes through 2 flops (s1, s2).
- Glitch filter, per channel:
  - 8-bit counter and a filtered bit f.
  - If s2 == f, the counter clears to 0.
  - Otherwise the counter increments. When the counter equals FILTER_LEN-1 and s2 != f still holds, f <= s2 and the counter clears.
- Arming:
  - An arm counter runs for FILTER_LEN+2 cycles after reset release.
  - While unarmed, the decoder prev state {Af,Bf} and the Z prev bit track the current values. No counting, no index, no errors.
  - The armed flag is sticky until reset.
- Decode: state = {Af,Bf}, compared against prev each cycle.
  - Forward sequence: 00→10→11→01→00. Each step does pos+1, dir<=1, count_strb=1.
  - Reverse sequence is the opposite order. Each step does pos-1, dir<=0, count_strb=1.
  - No change: nothing happens.
  - Both bits changed (00↔11, 10↔01): illegal. pos and dir are unchanged and err_count increments, holding at 255.
- Arithmetic: pos wraps modulo 2^CNT_WIDTH (0-1 = all ones; max+1 = 0). It is unsigned storage; the consumer interprets it as two's complement.
- Index:
  - On a Zf rising edge (prev 0, current 1), index_pos <= the value pos takes on the same edge, including any same-cycle step or clear. index_valid pulses.
  - A Z falling edge is ignored.
- Clear:
  - clr=1 forces pos <= 0 and suppresses count_strb that cycle, overriding any simultaneous step.
  - An illegal transition in the same cycle still increments err_count.
  - clr does not affect index_pos, err_count, or dir.

## Timing
- Reset values: pos=0, index_pos=0, index_valid=0, count_strb=0, dir=0, err_count=0, all sync/filter flops=0, filter counters=0, armed=0.
- Latency (with armed=1): raw pin edge settling before clk edge k gives:
  - s2 valid after edge k+1
  - f updated at edge k+1+FILTER_LEN
  - pos/count_strb/index_pos updated at edge k+2+FILTER_LEN
  - total FILTER_LEN+2 cycles (6 at default)
- Rejection: a pulse shorter than FILTER_LEN cycles at s2 never changes f.
- Outputs: all are registered. count_strb and index_valid are high for exactly one cycle per event.
- Maximum count rate: one step per FILTER_LEN cycles per channel. Faster input is filtered away rather than producing errors.
- Reset asserted mid-motion: all state returns to reset values immediately (async), and re-arming is required before counting resumes.

## Test plan
- Forward motion: from reset, wait 10 cycles, drive AB 00→10→11→01→00 with each step held 8 cycles. Required: pos=4, dir=1, 4 count_strb pulses, each 6 cycles after its pin edge.
- Reverse wrap: from pos=0 (armed), drive one reverse step 00→01. Required: pos=0xFFFFFFFF, dir=0; the following forward step returns pos=0.
- Glitch rejection (FILTER_LEN=4): A high for 3 cycles then low. Required: pos unchanged, no count_strb, err_count=0. Holding A high for 4 cycles gives pos=1.
- Illegal transition: AB 00→11 in one edge, held. Required: err_count=1, pos unchanged. Repeat 300 times: err_count=255.
- Index latch: forward to pos=7, raise Z coincident with the step to 8. Required: index_pos=8, one index_valid pulse; lowering Z gives no pulse.
- Clear priority: assert clr in the same cycle a forward step lands at pos=5. Required: pos=0, count_strb=0. Assert reset_n=0 mid-sequence: all outputs are 0 asynchronously.

Source files
------------

// File: rtl/qei_decoder.sv
// qei_decoder: quadrature encoder front end.
// Raw A/B/Z pins are synchronized, glitch filtered and decoded (x4) into a
// wrapping position counter. The counter is latched on each index rising edge,
// and illegal transitions are counted into a saturating error counter.
module qei_decoder #(
  parameter int FILTER_LEN = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [2:0]           encabz,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] pos,
  output logic [CNT_WIDTH-1:0] index_pos,
  output logic                 index_valid,
  output logic                 count_strb,
  output logic                 dir,
  output logic [7:0]           err_count
);

  localparam logic [7:0] FLT_LAST = 8'(FILTER_LEN - 1);
  localparam logic [8:0] ARM_LAST = 9'(FILTER_LEN + 1);

  // Channel order in every 3-bit vector: [2]=A, [1]=B, [0]=Z.
  logic [2:0] s1, s2, filt;
  logic [7:0] flt_cnt [3];

  logic [8:0] arm_cnt;
  logic       armed;

  logic [1:0] prev_ab;
  logic       prev_z;

  logic [1:0]           ph_cur, ph_prev, ph_delta;
  logic                 step_fwd, step_rev, step_bad, z_rise;
  logic [CNT_WIDTH-1:0] pos_next;

  // Two-flop synchronizer for the asynchronous pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= encabz;
      s2 <= s1;
    end
  end

  // Per-channel glitch filter: s2 must differ from filt for FILTER_LEN
  // consecutive cycles before filt follows it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt <= '0;
      for (int i = 0; i < 3; i++) flt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == filt[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == FLT_LAST) begin
          filt[i]    <= s2[i];
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + 8'd1;
        end
      end
    end
  end

  // Arm timer: decoding starts once the filters have had time to settle
  // after reset, so the power-up pin state is never seen as motion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt <= '0;
      armed   <= 1'b0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + 9'd1;
      if (arm_cnt == ARM_LAST) armed <= 1'b1;
    end
  end

  // Quadrature decode. Mapping AB to a phase (00,10,11,01 -> 0,1,2,3) turns
  // forward/reverse/illegal into a phase difference of 1/3/2.
  always_comb begin
    ph_cur   = {filt[1], filt[2] ^ filt[1]};
    ph_prev  = {prev_ab[0], prev_ab[1] ^ prev_ab[0]};
    ph_delta = ph_cur - ph_prev;
    step_fwd = armed && (ph_delta == 2'd1);
    step_rev = armed && (ph_delta == 2'd3);
    step_bad = armed && (ph_delta == 2'd2);
    z_rise   = armed && filt[0] && !prev_z;
    pos_next = pos;
    if (step_fwd) pos_next = pos + 1'b1;
    if (step_rev) pos_next = pos - 1'b1;
    if (clr)      pos_next = '0;
  end

  // Position, direction, index latch and error counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_ab     <= '0;
      prev_z      <= 1'b0;
      pos         <= '0;
      index_pos   <= '0;
      index_valid <= 1'b0;
      count_strb  <= 1'b0;
      dir         <= 1'b0;
      err_count   <= '0;
    end else begin
      prev_ab     <= filt[2:1];
      prev_z      <= filt[0];
      pos         <= pos_next;
      count_strb  <= (step_fwd || step_rev) && !clr;
      index_valid <= z_rise;
      if (z_rise)   index_pos <= pos_next;
      if (step_fwd) dir <= 1'b1;
      if (step_rev) dir <= 1'b0;
      if (step_bad && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_qei_decoder.sv
// tb_qei_decoder: directed bench for qei_decoder at default parameters
// (FILTER_LEN=4, CNT_WIDTH=32).
module tb_qei_decoder;

  logic        clk;
  logic        reset_n;
  logic [2:0]  encabz;
  logic        clr;
  logic [31:0] pos;
  logic [31:0] index_pos;
  logic        index_valid;
  logic        count_strb;
  logic        dir;
  logic [7:0]  err_count;

  int errors = 0;
  int checks = 0;
  int strb_seen = 0;
  int iv_seen = 0;
  int snap_strb;
  int snap_iv;

  qei_decoder dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .encabz      (encabz),
    .clr         (clr),
    .pos         (pos),
    .index_pos   (index_pos),
    .index_valid (index_valid),
    .count_strb  (count_strb),
    .dir         (dir),
    .err_count   (err_count)
  );

  // Clock: 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (count_strb)  strb_seen++;
    if (index_valid) iv_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive pins at a negedge, then check that the result appears exactly
  // 6 clock edges after the pins settle and lasts one cycle.
  task automatic step(input logic [2:0] pins, input logic exp_strb,
                      input logic [31:0] exp_pos, input logic exp_dir,
                      input logic [7:0] exp_err, input logic exp_iv,
                      input string tag);
    encabz = pins;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk({tag, "_early_strb"}, {31'd0, count_strb}, 32'd0);
    chk({tag, "_early_iv"}, {31'd0, index_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_strb"}, {31'd0, count_strb}, {31'd0, exp_strb});
    chk({tag, "_pos"}, pos, exp_pos);
    chk({tag, "_dir"}, {31'd0, dir}, {31'd0, exp_dir});
    chk({tag, "_err"}, {24'd0, err_count}, {24'd0, exp_err});
    chk({tag, "_iv"}, {31'd0, index_valid}, {31'd0, exp_iv});
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_strb_off"}, {31'd0, count_strb}, 32'd0);
    chk({tag, "_iv_off"}, {31'd0, index_valid}, 32'd0);
  endtask

  initial begin
    // Reset state
    reset_n = 1'b0;
    encabz  = 3'b000;
    clr     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pos", pos, 32'd0);
    chk("rst_index_pos", index_pos, 32'd0);
    chk("rst_iv", {31'd0, index_valid}, 32'd0);
    chk("rst_strb", {31'd0, count_strb}, 32'd0);
    chk("rst_dir", {31'd0, dir}, 32'd0);
    chk("rst_err", {24'd0, err_count}, 32'd0);
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("armed_idle_pos", pos, 32'd0);

    // Forward motion 00->10->11->01->00
    snap_strb = strb_seen;
    step(3'b100, 1'b1, 32'd1, 1'b1, 8'd0, 1'b0, "fwd1");
    step(3'b110, 1'b1, 32'd2, 1'b1, 8'd0, 1'b0, "fwd2");
    step(3'b010, 1'b1, 32'd3, 1'b1, 8'd0, 1'b0, "fwd3");
    step(3'b000, 1'b1, 32'd4, 1'b1, 8'd0, 1'b0, "fwd4");
    chk("fwd_strb_pulses", 32'(strb_seen - snap_strb), 32'd4);

    // Clear, then reverse wrap below zero and back
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    chk("clr_pos", pos, 32'd0);
    chk("clr_keeps_dir", {31'd0, dir}, 32'd1);
    step(3'b010, 1'b1, 32'hFFFF_FFFF, 1'b0, 8'd0, 1'b0, "rev_wrap");
    step(3'b000, 1'b1, 32'd0, 1'b1, 8'd0, 1'b0, "fwd_unwrap");

    // Glitch rejection: A high for 3 cycles only
    snap_strb = strb_seen;
    encabz = 3'b100;
    repeat (3) @(posedge clk);
    #1 encabz = 3'b000;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("glitch_pos", pos, 32'd0);
    chk("glitch_err", {24'd0, err_count}, 32'd0);
    chk("glitch_strb", 32'(strb_seen - snap_strb), 32'd0);
    step(3'b100, 1'b1, 32'd1, 1'b1, 8'd0, 1'b0, "held4");
    step(3'b000, 1'b1, 32'd0, 1'b0, 8'd0, 1'b0, "held4_back");

    // Illegal transition 00->11, then saturate the error counter
    step(3'b110, 1'b0, 32'd0, 1'b0, 8'd1, 1'b0, "illegal1");
    for (int i = 0; i < 300; i++) begin
      encabz = (i % 2 == 0) ? 3'b000 : 3'b110;
      repeat (7) @(posedge clk);
    end
    @(negedge clk);
    chk("err_sat", {24'd0, err_count}, 32'd255);
    chk("err_sat_pos", pos, 32'd0);
    encabz = 3'b000;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("err_hold", {24'd0, err_count}, 32'd255);

    // Index latch with Z rising on the step to 8
    step(3'b100, 1'b1, 32'd1, 1'b1, 8'd255, 1'b0, "idx1");
    step(3'b110, 1'b1, 32'd2, 1'b1, 8'd255, 1'b0, "idx2");
    step(3'b010, 1'b1, 32'd3, 1'b1, 8'd255, 1'b0, "idx3");
    step(3'b000, 1'b1, 32'd4, 1'b1, 8'd255, 1'b0, "idx4");
    step(3'b100, 1'b1, 32'd5, 1'b1, 8'd255, 1'b0, "idx5");
    step(3'b110, 1'b1, 32'd6, 1'b1, 8'd255, 1'b0, "idx6");
    step(3'b010, 1'b1, 32'd7, 1'b1, 8'd255, 1'b0, "idx7");
    step(3'b001, 1'b1, 32'd8, 1'b1, 8'd255, 1'b1, "idx8_z");
    chk("index_pos", index_pos, 32'd8);
    snap_iv = iv_seen;
    encabz = 3'b000;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("z_fall_no_pulse", 32'(iv_seen - snap_iv), 32'd0);
    chk("z_fall_index_pos", index_pos, 32'd8);
    chk("z_fall_pos", pos, 32'd8);

    // Clear priority over a step landing at pos=5
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    chk("clr2_pos", pos, 32'd0);
    chk("clr2_index_pos", index_pos, 32'd8);
    chk("clr2_err", {24'd0, err_count}, 32'd255);
    step(3'b100, 1'b1, 32'd1, 1'b1, 8'd255, 1'b0, "cp1");
    step(3'b110, 1'b1, 32'd2, 1'b1, 8'd255, 1'b0, "cp2");
    step(3'b010, 1'b1, 32'd3, 1'b1, 8'd255, 1'b0, "cp3");
    step(3'b000, 1'b1, 32'd4, 1'b1, 8'd255, 1'b0, "cp4");
    encabz = 3'b100;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("cp5_pre_pos", pos, 32'd4);
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    chk("cp5_pos", pos, 32'd0);
    chk("cp5_strb", {31'd0, count_strb}, 32'd0);
    chk("cp5_dir", {31'd0, dir}, 32'd1);
    step(3'b110, 1'b1, 32'd1, 1'b1, 8'd255, 1'b0, "after_clr");

    // Asynchronous reset mid-sequence
    encabz = 3'b010;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_pos", pos, 32'd0);
    chk("async_index_pos", index_pos, 32'd0);
    chk("async_iv", {31'd0, index_valid}, 32'd0);
    chk("async_strb", {31'd0, count_strb}, 32'd0);
    chk("async_dir", {31'd0, dir}, 32'd0);
    chk("async_err", {24'd0, err_count}, 32'd0);
    encabz = 3'b000;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("rearm_idle_pos", pos, 32'd0);
    step(3'b100, 1'b1, 32'd1, 1'b1, 8'd0, 1'b0, "rearm");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
